// File: rtl/bfly_switch_ctrl.sv
// bfly_switch_ctrl: 2x2 butterfly switch element for one stage.
// Each input has a one-flit buffer. The flit's output port is src[LEVEL] ^ dest[LEVEL].
// Each output has its own round-robin arbiter and a registered valid/ready port.
module bfly_switch_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int LEVEL  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [ADDR_W-1:0] in0_src,
    input  logic [ADDR_W-1:0] in0_dest,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [ADDR_W-1:0] in1_src,
    input  logic [ADDR_W-1:0] in1_dest,
    input  logic [DATA_W-1:0] in1_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [ADDR_W-1:0] out0_src,
    output logic [ADDR_W-1:0] out0_dest,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [ADDR_W-1:0] out1_src,
    output logic [ADDR_W-1:0] out1_dest,
    output logic [DATA_W-1:0] out1_data,
    output logic [15:0]       stall_cnt
);

    logic              buf0_valid, buf1_valid;
    logic [ADDR_W-1:0] buf0_src, buf0_dest, buf1_src, buf1_dest;
    logic [DATA_W-1:0] buf0_data, buf1_data;
    logic              rr_ptr0, rr_ptr1;
    logic              req0, req1;
    logic              free0, free1;
    logic              g00, g01, g10, g11;
    logic              grant0, grant1;
    logic              stalled;

    assign req0   = buf0_src[LEVEL] ^ buf0_dest[LEVEL];
    assign req1   = buf1_src[LEVEL] ^ buf1_dest[LEVEL];
    assign free0  = !out0_valid || out0_ready;
    assign free1  = !out1_valid || out1_ready;
    assign grant0 = g00 || g10;
    assign grant1 = g01 || g11;
    assign stalled = (buf0_valid && !grant0) || (buf1_valid && !grant1);

    // The grant term lets an input accept a new flit in the same cycle its buffered flit leaves.
    assign in0_ready = !rst && (!buf0_valid || grant0);
    assign in1_ready = !rst && (!buf1_valid || grant1);

    // Per-output arbitration: gXY means output X grants input Y. A tie goes to the input rr_ptrX points to.
    always_comb begin
        g00 = 1'b0;
        g01 = 1'b0;
        g10 = 1'b0;
        g11 = 1'b0;
        if (free0) begin
            if (buf0_valid && !req0 && buf1_valid && !req1) begin
                g00 = !rr_ptr0;
                g01 = rr_ptr0;
            end else begin
                g00 = buf0_valid && !req0;
                g01 = buf1_valid && !req1;
            end
        end
        if (free1) begin
            if (buf0_valid && req0 && buf1_valid && req1) begin
                g10 = !rr_ptr1;
                g11 = rr_ptr1;
            end else begin
                g10 = buf0_valid && req0;
                g11 = buf1_valid && req1;
            end
        end
    end

    // Input buffers: if a load and a grant happen on the same edge, the new flit replaces the departing one.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_valid <= 1'b0;
            buf0_src   <= '0;
            buf0_dest  <= '0;
            buf0_data  <= '0;
            buf1_valid <= 1'b0;
            buf1_src   <= '0;
            buf1_dest  <= '0;
            buf1_data  <= '0;
        end else begin
            if (in0_valid && in0_ready) begin
                buf0_valid <= 1'b1;
                buf0_src   <= in0_src;
                buf0_dest  <= in0_dest;
                buf0_data  <= in0_data;
            end else if (grant0) begin
                buf0_valid <= 1'b0;
            end
            if (in1_valid && in1_ready) begin
                buf1_valid <= 1'b1;
                buf1_src   <= in1_src;
                buf1_dest  <= in1_dest;
                buf1_data  <= in1_data;
            end else if (grant1) begin
                buf1_valid <= 1'b0;
            end
        end
    end

    // Output registers load the granted flit and drop valid after a handshake. Fields hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out0_valid <= 1'b0;
            out0_src   <= '0;
            out0_dest  <= '0;
            out0_data  <= '0;
            out1_valid <= 1'b0;
            out1_src   <= '0;
            out1_dest  <= '0;
            out1_data  <= '0;
        end else begin
            if (g00 || g01) begin
                out0_valid <= 1'b1;
                out0_src   <= g00 ? buf0_src  : buf1_src;
                out0_dest  <= g00 ? buf0_dest : buf1_dest;
                out0_data  <= g00 ? buf0_data : buf1_data;
            end else if (out0_ready) begin
                out0_valid <= 1'b0;
            end
            if (g10 || g11) begin
                out1_valid <= 1'b1;
                out1_src   <= g10 ? buf0_src  : buf1_src;
                out1_dest  <= g10 ? buf0_dest : buf1_dest;
                out1_data  <= g10 ? buf0_data : buf1_data;
            end else if (out1_ready) begin
                out1_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointers move to the losing input after every grant and hold while their output is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr0 <= 1'b0;
            rr_ptr1 <= 1'b0;
        end else begin
            if (g00) begin
                rr_ptr0 <= 1'b1;
            end else if (g01) begin
                rr_ptr0 <= 1'b0;
            end
            if (g10) begin
                rr_ptr1 <= 1'b1;
            end else if (g11) begin
                rr_ptr1 <= 1'b0;
            end
        end
    end

    // Saturating count of cycles in which some buffered flit was not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/bfly_switch_ctrl.md
# bfly_switch_ctrl

2x2 butterfly switch-element controller for one butterfly stage. It buffers one flit per input and computes each flit's output port from its source/destination address bit at this stage's level. It arbitrates contention for each output with per-output round-robin and drives registered valid/ready outputs. It sits between two upstream links and two downstream links, and is instantiated once per switch with `LEVEL` set per stage.

## Interface
Parameters:
- `ADDR_W`, 3: width of source/destination address.
- `DATA_W`, 8: payload width.
- `LEVEL`, 0: address bit examined by this stage (0 .. ADDR_W-1).

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in0_valid` / `in1_valid`, input, 1: upstream flit present.
- `in0_ready` / `in1_ready`, output, 1: input buffer can accept this cycle.
- `in0_src` / `in1_src`, input, ADDR_W: flit source address.
- `in0_dest` / `in1_dest`, input, ADDR_W: flit destination address.
- `in0_data` / `in1_data`, input, DATA_W: payload.
- `out0_valid` / `out1_valid`, output, 1: registered flit present on output.
- `out0_ready` / `out1_ready`, input, 1: downstream accepts this cycle.
- `out0_src`, `out0_dest`, `out0_data` / `out1_*`, output, ADDR_W/ADDR_W/DATA_W: registered flit fields, passed unmodified.
- `stall_cnt`, output, 16: saturating count of cycles in which any buffered flit was denied.

## Operation
- Each input owns a one-entry buffer (valid bit plus src/dest/data), loaded on `inX_valid && inX_ready`.
- Route bit for a buffered flit: `req_port = src[LEVEL] ^ dest[LEVEL]`.
  - 0 means output 0; 1 means output 1.
  - Input index plays no role in the port choice.
- Output X is free when `!outX_valid || outX_ready`.
- Arbitration per free output X, over the buffered flits whose `req_port == X`:
  - One requester: it is granted.
  - Two requesters: grant the input equal to `rr_ptrX`.
  - After any grant, `rr_ptrX` is set to the index of the non-granted input.
  - An output that is not free grants nothing, and `rr_ptrX` holds.
- A granted flit is copied into output register X and its input buffer clears in the same edge.
- `inX_ready = !bufX_valid || grantX`. This is combinational from `grantX`, which depends on `outY_ready`, so each input sustains one flit per cycle when uncontended.
- Simultaneous clear and load of a buffer on the same edge: the new flit wins, and the buffer stays valid.
- Output register X clears on `outX_valid && outX_ready` unless it is reloaded on the same edge.
- Output fields hold stable while `outX_valid && !outX_ready`.
- Two flits routed to different outputs are both granted in the same cycle; there is no coupling between the outputs.
- `stall_cnt` increments by 1 in each cycle where at least one buffer is valid and not granted.
  - It saturates at 16'hFFFF.
  - It does not wrap.

## Timing
- Reset (synchronous, `rst` high at an edge) sets:
  - all buffer valids and `outX_valid` to 0;
  - `out*_src`, `out*_dest`, `out*_data` to 0;
  - `rr_ptr0` and `rr_ptr1` to 0 (input 0 preferred);
  - `stall_cnt` to 0.
- While `rst` is high, `in0_ready` and `in1_ready` are driven 0.
- Reset mid-operation discards all buffered and output flits with no drain. The first acceptance is possible at the first edge with `rst` low.
- Latency with the output free: flit accepted at edge N, granted in cycle N+1, `outX_valid` high after edge N+1. This is 2 cycles input-to-output.
- Throughput: 1 flit per cycle per output with `outX_ready` held high.
- Contention: two flits to one output drain on consecutive cycles in round-robin order.
- Backpressure propagates to `inX_ready` with zero extra cycles, via the `grantX` term.
- No flit is dropped, duplicated or reordered per input.

## Test plan
- Straight routing, `LEVEL=0`: in0 sends src=3'b000, dest=3'b010; in1 sends src=3'b001, dest=3'b111, same cycle. Both route to output 0, since bit0 XOR is 0 for both. Required: in0's flit appears on out0 at N+1 and in1's flit at N+2 (`rr_ptr0`=0 at reset), `stall_cnt`=1.
- Cross routing, `LEVEL=1`: in0 sends src=3'b000, dest=3'b010 (goes to out1); in1 sends src=3'b010, dest=3'b010 (goes to out0). Required: both outputs valid at N+1 with matching data, `stall_cnt`=0.
- Round-robin fairness: both inputs stream continuously to output 1 with `out1_ready`=1. Required: out1 alternates in0/in1 every cycle and each `inX_ready` toggles at half rate.
- Backpressure: hold `out0_ready`=0 for 5 cycles with flits queued on both inputs. Required:
  - out0 fields stay stable;
  - both `inX_ready` are 0 once the buffers fill;
  - `stall_cnt` increments each cycle;
  - after release, no flit is lost.
- Reset mid-traffic: assert `rst` for 1 cycle with all buffers and outputs full. Required: all valids 0, data outputs 0, `stall_cnt`=0 after the edge; the first new flit reaches the output 2 cycles after `rst` falls.
- Saturation: force 70000 stalled cycles. Required: `stall_cnt` holds at 16'hFFFF.
